tff_bank_sequencer: RTL and testbench
=====================================

Name: tff_bank_sequencer

Overview:
- Controller that sequences a WIDTH-bit bank of toggle flip-flops (built inside the block as q <= q ^ t_vec) as a start/stop up/down counter.
- Generates the per-bit toggle vector each cycle, handles start/pause/stop control, detects the terminal count and signals completion.
- Used as the timing/sequence source in the sequential library and as the canonical driver for T-FF banks.

Parameters:
- WIDTH, 8, number of T flip-flops in the bank (count width); legal range 2..16.

Ports:
- clk     input   1      rising-edge clock
- reset   input   1      synchronous, active-low reset (0 = reset, sampled on rising clk)
- start   input   1      begin a run; honoured only in IDLE
- pause   input   1      level; holds the count while RUN/HOLD
- stop    input   1      abort the run; returns to IDLE, count frozen
- up_dn   input   1      1 = count up 0..limit, 0 = count down limit..0; sampled with start
- limit   input   WIDTH  terminal (up) / start value (down); sampled with start
- t_vec   output  WIDTH  toggle vector applied to the bank this cycle
- count   output  WIDTH  T-FF bank state
- busy    output  1      1 in RUN or HOLD
- done    output  1      1-cycle pulse on reaching terminal count

Behaviour:
- Reset (reset==0 at rising clk):
  - state=IDLE, count=0, dir_r=1, lim_r=0, done=0, busy=0.
  - Reset wins over every other input, including mid-run.
- Bank update every cycle: count <= count ^ t_vec. t_vec is combinational from state, count and dir_r.
- Toggle rule when enabled:
  - Up: t_vec[0]=1; t_vec[i]=&count[i-1:0].
  - Down: t_vec[0]=1; t_vec[i]=&(~count[i-1:0]).
  - Wrap-around is therefore natural mod 2^WIDTH, but it never occurs in a run (see terminal rule).
- States: IDLE, RUN, HOLD, DONE.
- IDLE:
  - t_vec=0.
  - On start: lim_r<=limit, dir_r<=up_dn, count<=(up_dn ? 0 : limit), next RUN. The load overrides the XOR update.
- RUN:
  - Terminal = (dir_r ? count==lim_r : count==0).
  - Priority: stop > terminal > pause > toggle.
  - stop: t_vec=0, next IDLE.
  - Terminal: t_vec=0, next DONE.
  - pause: t_vec=0, next HOLD.
  - Otherwise: t_vec enabled, stay in RUN.
- HOLD:
  - t_vec=0.
  - stop -> IDLE; pause==0 -> RUN (toggling resumes on the following cycle); else stay in HOLD.
- DONE:
  - t_vec=0, done=1 for exactly one cycle, next IDLE.
  - count holds the terminal value until the next start.
- start is ignored outside IDLE. limit and up_dn changes mid-run have no effect.
- busy=1 in RUN and HOLD; 0 in IDLE and DONE. done is registered-state-decoded, with no glitch.
- Latency:
  - start sampled at edge E0 -> RUN and loaded at E0.
  - First toggle at E1.
  - Up run with limit L: count reaches L at edge E_L.
  - DONE is entered one edge after count reaches L; done high for the cycle after that edge.
  - Total start-to-done = L+1 edges. Down runs are symmetric.
- limit==0 (either direction): terminal on the first RUN cycle, no toggles, done after 1 RUN cycle.
- pause and stop asserted together: stop wins. stop in DONE is ignored (done still pulses).

Optional Feature:
- Macro: TFF_AUTO_RELOAD_EN.
- Defined:
  - DONE reloads count (0 for up / lim_r for down), keeps lim_r/dir_r, and returns to RUN instead of IDLE.
  - done still pulses 1 cycle per period; busy stays 1 through DONE.
  - stop in DONE -> IDLE.
  - Period = L+2 cycles.
- Undefined: DONE -> IDLE as above; no reload logic is synthesised.

Test Plan:
- Mid-run reset: reset=0 for 2 cycles mid-run -> count=0, state IDLE, busy=0, done=0; start then works normally.
- Up count: WIDTH=8, start, up_dn=1, limit=5.
  - count sequence 0,1,2,3,4,5.
  - t_vec while counting: 01,03,01,07,01; t_vec=00 on the terminal cycle.
  - done pulses exactly once, L+1 = 6 edges after start.
  - busy=1 during the run; count holds 5 afterwards.
- Down count with toggle check: up_dn=0, limit=8'h10.
  - First toggle from 8'h10 gives t_vec=8'h1F -> count 8'h0F.
  - Counts to 0, then done.
- Pause/stop priority: pause for 3 cycles at count=3 -> count frozen at 3 and busy=1; resumes to 4 one cycle after release. stop with pause both high at count=4 -> IDLE, count stays 4, no done.
- Boundary values:
  - limit=0 -> done after 1 RUN cycle, count=0.
  - limit=8'hFF up -> count reaches FF without wrapping, then done.
  - start pulses during RUN -> ignored.
- With TFF_AUTO_RELOAD_EN, limit=3 up:
  - done pulses every 5 cycles, count cycles 0..3.
  - stop during DONE -> IDLE after that pulse.

Source files
------------

// File: rtl/tff_bank_sequencer_if.sv
// tff_bank_sequencer_if
//   Control/status bundle for the T-FF bank sequencer.
//   master : the controlling block (drives start/pause/stop/up_dn/limit,
//            observes t_vec/count/busy/done)
//   slave  : the sequencer itself
//   Signals:
//     start  - begin a run (honoured only while idle)
//     pause  - level, holds the count while running
//     stop   - abort the run, count frozen
//     up_dn  - 1 = count up to limit, 0 = count down from limit
//     limit  - terminal value (up) / start value (down)
//     t_vec  - toggle vector applied to the bank this cycle
//     count  - bank state
//     busy   - run in progress
//     done   - one-cycle pulse on terminal count
interface tff_bank_sequencer_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             pause;
  logic             stop;
  logic             up_dn;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] t_vec;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output start, pause, stop, up_dn, limit,
    input  t_vec, count, busy, done
  );

  modport slave (
    input  start, pause, stop, up_dn, limit,
    output t_vec, count, busy, done
  );

endinterface

// File: rtl/tff_bank_sequencer.sv
// tff_bank_sequencer
//   Sequences a WIDTH-bit bank of toggle flip-flops (q <= q ^ t_vec) as a
//   start/pause/stop up/down counter. A run counts from 0 up to limit, or
//   from limit down to 0, then pulses done for one cycle.
//   Ports:
//     clk   - rising-edge clock
//     reset - synchronous, active-low reset
//     bus   - tff_bank_sequencer_if.slave (start/pause/stop/up_dn/limit in,
//             t_vec/count/busy/done out)
//   Parameters:
//     WIDTH - number of T flip-flops in the bank (2..16)
//   Build option:
//     TFF_AUTO_RELOAD_EN - when defined, the DONE state reloads the bank and
//     starts the next period automatically instead of returning to idle.
module tff_bank_sequencer #(
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 reset,
  tff_bank_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] lim_r;
  logic [WIDTH-1:0] lim_nxt;
  logic             dir_r;
  logic             dir_nxt;
  logic [WIDTH-1:0] t_vec;
  logic [WIDTH-1:0] up_t;
  logic [WIDTH-1:0] dn_t;
  logic             terminal;
  logic             toggle_en;

  // A bit toggles when every lower bit is 1 (counting up) or every lower
  // bit is 0 (counting down); bit 0 always toggles.
  assign up_t[0] = 1'b1;
  assign dn_t[0] = 1'b1;

  for (genvar i = 1; i < WIDTH; i++) begin : g_toggle
    assign up_t[i] = &count[i-1:0];
    assign dn_t[i] = &(~count[i-1:0]);
  end

  // The run ends when the bank sits on the far end of its range, so the
  // natural mod-2^WIDTH wrap of the toggle rule is never exercised.
  assign terminal = dir_r ? (count == lim_r) : (count == '0);

  // Toggling is enabled only in a RUN cycle that is not stopped, not at the
  // terminal value and not paused.
  always_comb begin
    toggle_en = 1'b0;
    if (state == RUN && !bus.stop && !terminal && !bus.pause) begin
      toggle_en = 1'b1;
    end
  end

  assign t_vec = toggle_en ? (dir_r ? up_t : dn_t) : '0;

  // Next-state logic. The bank is a plain T-FF update by default; a start
  // (and, with auto-reload, the end of a period) overrides it with a load.
  always_comb begin
    state_nxt = state;
    count_nxt = count ^ t_vec;
    lim_nxt   = lim_r;
    dir_nxt   = dir_r;
    case (state)
      IDLE: begin
        if (bus.start) begin
          lim_nxt   = bus.limit;
          dir_nxt   = bus.up_dn;
          count_nxt = bus.up_dn ? '0 : bus.limit;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (terminal) begin
          state_nxt = DONE;
        end else if (bus.pause) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (!bus.pause) begin
          state_nxt = RUN;
        end
      end
      DONE: begin
`ifdef TFF_AUTO_RELOAD_EN
        if (bus.stop) begin
          state_nxt = IDLE;
        end else begin
          count_nxt = dir_r ? '0 : lim_r;
          state_nxt = RUN;
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register and the T-FF bank; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      count <= '0;
      lim_r <= '0;
      dir_r <= 1'b1;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      lim_r <= lim_nxt;
      dir_r <= dir_nxt;
    end
  end

  // Status is decoded straight from the state register so done cannot glitch.
  assign bus.t_vec = t_vec;
  assign bus.count = count;
  assign bus.done  = (state == DONE);
`ifdef TFF_AUTO_RELOAD_EN
  assign bus.busy  = (state == RUN) || (state == HOLD) || (state == DONE);
`else
  assign bus.busy  = (state == RUN) || (state == HOLD);
`endif

endmodule

// File: tb/tb_tff_bank_sequencer.sv
// tb_tff_bank_sequencer
//   Self-checking bench for tff_bank_sequencer (WIDTH=8). A behavioural
//   model tracks the run as an integer counter and derives the expected
//   toggle vector as count XOR next_count.
module tb_tff_bank_sequencer;

  localparam int WIDTH  = 8;
  localparam int MASK   = (1 << WIDTH) - 1;
  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_HOLD = 2;
  localparam int P_DONE = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  tff_bank_sequencer_if #(.WIDTH(WIDTH)) ifc ();

  tff_bank_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int checks     = 0;
  int failures   = 0;
  int cycleCount = 0;
  int startCycle = 0;
  int doneCycle  = -1;
  int doneSeen   = 0;

  int mPh;
  int mCount;
  int mLim;
  bit mDir;

  task automatic checkOne(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycleCount);
    end
  endtask

  function automatic int modelNext();
    return mDir ? ((mCount + 1) & MASK) : ((mCount - 1) & MASK);
  endfunction

  function automatic bit modelTerminal();
    return mDir ? (mCount == mLim) : (mCount == 0);
  endfunction

  task automatic checkOutput();
    bit active;
    int expT;
    bit expBusy;
    active  = (mPh == P_RUN) && !ifc.stop && !modelTerminal() && !ifc.pause;
    expT    = active ? (mCount ^ modelNext()) : 0;
`ifdef TFF_AUTO_RELOAD_EN
    expBusy = (mPh == P_RUN) || (mPh == P_HOLD) || (mPh == P_DONE);
`else
    expBusy = (mPh == P_RUN) || (mPh == P_HOLD);
`endif
    checkOne("t_vec", 16'(ifc.t_vec), 16'(expT));
    checkOne("count", 16'(ifc.count), 16'(mCount));
    checkOne("busy",  16'(ifc.busy),  16'(expBusy));
    checkOne("done",  16'(ifc.done),  16'(mPh == P_DONE));
    if (ifc.done === 1'b1) begin
      doneSeen++;
      doneCycle = cycleCount;
    end
  endtask

  task automatic modelStep(input bit rst, input bit s, input bit p, input bit st,
                           input bit ud, input int lim);
    if (!rst) begin
      mPh = P_IDLE; mCount = 0; mDir = 1'b1; mLim = 0;
    end else begin
      case (mPh)
        P_IDLE: if (s) begin
          mLim = lim; mDir = ud; mCount = ud ? 0 : lim; mPh = P_RUN;
        end
        P_RUN: begin
          if (st) mPh = P_IDLE;
          else if (modelTerminal()) mPh = P_DONE;
          else if (p) mPh = P_HOLD;
          else mCount = modelNext();
        end
        P_HOLD: begin
          if (st) mPh = P_IDLE;
          else if (!p) mPh = P_RUN;
        end
        default: begin
`ifdef TFF_AUTO_RELOAD_EN
          if (st) mPh = P_IDLE;
          else begin
            mCount = mDir ? 0 : mLim; mPh = P_RUN;
          end
`else
          mPh = P_IDLE;
`endif
        end
      endcase
    end
  endtask

  // Called at the falling edge: drive, check the settled outputs, advance
  // the model, then cross the next rising edge.
  task automatic applyStimulus(input bit rst, input bit s, input bit p, input bit st,
                               input bit ud, input logic [WIDTH-1:0] lim);
    reset     = rst;
    ifc.start = s;
    ifc.pause = p;
    ifc.stop  = st;
    ifc.up_dn = ud;
    ifc.limit = lim;
    #1;
    checkOutput();
    modelStep(rst, s, p, st, ud, int'(lim));
    @(posedge clk);
    @(negedge clk);
    cycleCount++;
  endtask

  // Idle cycles with noise on up_dn/limit, which must have no effect.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), WIDTH'($urandom));
    end
  endtask

  task automatic startRun(input bit ud, input logic [WIDTH-1:0] lim);
    doneSeen = 0;
    doneCycle = -1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, ud, lim);
    startCycle = cycleCount;
  endtask

  initial begin
    reset     = 1'b0;
    ifc.start = 1'b0;
    ifc.pause = 1'b0;
    ifc.stop  = 1'b0;
    ifc.up_dn = 1'b0;
    ifc.limit = '0;
    mPh = P_IDLE; mCount = 0; mDir = 1'b1; mLim = 0;
    @(posedge clk);
    @(negedge clk);

    // Reset state
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd9);
    checkOne("reset_count", 16'(ifc.count), 16'd0);
    checkOne("reset_busy",  16'(ifc.busy),  16'd0);

    // Up count to 5
    startRun(1'b1, 8'd5);
    idle(9);
`ifndef TFF_AUTO_RELOAD_EN
    checkOne("up_final_count", 16'(ifc.count), 16'd5);
    checkOne("up_done_once",   16'(doneSeen), 16'd1);
    checkOne("up_done_latency", 16'(doneCycle - startCycle), 16'd6);
`endif

    // Down count from 0x10
    startRun(1'b0, 8'h10);
    checkOne("down_first_tvec", 16'(ifc.t_vec), 16'h1F);
    idle(1);
    checkOne("down_second_count", 16'(ifc.count), 16'h0F);
    idle(18);
`ifndef TFF_AUTO_RELOAD_EN
    checkOne("down_final_count", 16'(ifc.count), 16'd0);
    checkOne("down_done_once",   16'(doneSeen), 16'd1);
`endif

    // Pause at 3, resume, then stop together with pause at 4
    startRun(1'b1, 8'd10);
    idle(3);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    checkOne("pause_count", 16'(ifc.count), 16'd3);
    checkOne("pause_busy",  16'(ifc.busy),  16'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    checkOne("resume_count_held", 16'(ifc.count), 16'd3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    checkOne("resume_count", 16'(ifc.count), 16'd4);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    idle(3);
    checkOne("stop_count",    16'(ifc.count), 16'd4);
    checkOne("stop_busy",     16'(ifc.busy),  16'd0);
    checkOne("stop_no_done",  16'(doneSeen),  16'd0);

    // limit == 0 in both directions
    startRun(1'b1, 8'd0);
    idle(3);
    checkOne("zero_up_latency", 16'(doneCycle - startCycle), 16'd1);
    checkOne("zero_up_count",   16'(ifc.count), 16'd0);
`ifdef TFF_AUTO_RELOAD_EN
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
`endif
    startRun(1'b0, 8'd0);
    idle(3);
    checkOne("zero_dn_latency", 16'(doneCycle - startCycle), 16'd1);
`ifdef TFF_AUTO_RELOAD_EN
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
`endif

    // Full-range up count with start pulses during the run
    startRun(1'b1, 8'hFF);
    for (int i = 0; i < 258; i++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 3) == 0), 1'b0, 1'b0,
                    1'($urandom_range(0, 1)), WIDTH'($urandom));
    end
    checkOne("ff_done_latency", 16'(doneCycle - startCycle), 16'd256);
`ifndef TFF_AUTO_RELOAD_EN
    checkOne("ff_final_count", 16'(ifc.count), 16'hFF);
`else
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
`endif

    // Mid-run reset, then a normal run
    startRun(1'b1, 8'd20);
    idle(5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
    checkOne("midreset_count", 16'(ifc.count), 16'd0);
    checkOne("midreset_busy",  16'(ifc.busy),  16'd0);
    checkOne("midreset_done",  16'(ifc.done),  16'd0);
    startRun(1'b0, 8'd3);
    idle(6);
    checkOne("after_reset_done", 16'(doneSeen > 0), 16'd1);
`ifdef TFF_AUTO_RELOAD_EN
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
`endif

`ifdef TFF_AUTO_RELOAD_EN
    // Auto-reload: period L+2, then stop on a DONE cycle
    startRun(1'b1, 8'd3);
    idle(15);
    checkOne("reload_done_count", 16'(doneSeen), 16'd3);
    begin
      bit stopped = 1'b0;
      for (int i = 0; i < 10 && !stopped; i++) begin
        if (mPh == P_DONE) begin
          applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
          stopped = 1'b1;
        end else begin
          idle(1);
        end
      end
      checkOne("reload_stop_reached", 16'(stopped), 16'd1);
    end
    idle(2);
    checkOne("reload_stop_busy", 16'(ifc.busy), 16'd0);
`endif

    // Randomized runs with random pause/stop/start/reset
    for (int r = 0; r < 20; r++) begin
      int lim;
      lim = $urandom_range(0, 30);
      startRun(1'($urandom_range(0, 1)), WIDTH'(lim));
      for (int c = 0; c < lim + 12; c++) begin
        applyStimulus(1'($urandom_range(0, 99) != 0),
                      1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 7) == 0),
                      1'($urandom_range(0, 39) == 0),
                      1'($urandom_range(0, 1)),
                      WIDTH'($urandom));
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      idle(2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
